// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals for ram_port_arbiter.
// The arbiter connects through the slave modport; requesters and RAM drive the master side.
interface ram_port_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_ren;
  logic [NREQ-1:0]      req_wen;
  logic [32*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_store;
  logic [NREQ-1:0]      req_wait;
  logic [31:0]          req_load;
  logic                 ramREN;
  logic                 ramWEN;
  logic [31:0]          ramaddr;
  logic [31:0]          ramstore;
  logic [31:0]          ramload;
  logic [1:0]           ramstate;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err;

  modport slave (
    input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy, err
  );

  modport master (
    output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy, err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with burst locking,
// per-beat timeout and a sticky error flag.
module ram_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int BURST   = 2,
  parameter int TIMEOUT = 255
) (
  input logic               CLK,
  input logic               nRST,
  ram_port_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(BURST) + 1;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_grant, w_grant_nxt;
  logic [IDW-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [BCW-1:0]  r_beat, w_beat_nxt;
  logic [7:0]      r_to, w_to_nxt;
  logic            r_err, w_err_nxt;
  logic [NREQ-1:0] w_req;
  logic [IDW-1:0]  w_pick, w_idx;
  logic            w_found;
  logic            w_g_ren, w_g_wen, w_active;
  logic [31:0]     w_g_addr, w_g_store;
  logic            w_done, w_release;

  assign w_req     = bus.req_ren | bus.req_wen;
  assign w_g_ren   = bus.req_ren[r_grant];
  assign w_g_wen   = bus.req_wen[r_grant];
  assign w_active  = w_g_ren | w_g_wen;
  assign w_g_addr  = bus.req_addr[{r_grant, 5'b00000} +: 32];
  assign w_g_store = bus.req_store[{r_grant, 5'b00000} +: 32];

  // Round-robin search: first active requester starting at r_rr_ptr.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && w_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state: arbitration, beat counting, timeout and release.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_beat_nxt   = r_beat;
    w_to_nxt     = r_to;
    w_err_nxt    = r_err;
    w_done       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_GRANT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!w_active) begin
          w_release = 1'b1;
        end else if (bus.ramstate == RS_ERROR) begin
          w_err_nxt = 1'b1;
          w_release = 1'b1;
        end else if (bus.ramstate == RS_ACCESS) begin
          w_done   = 1'b1;
          w_to_nxt = 8'h00;
          if (r_beat == BCW'(BURST - 1)) begin
            w_release = 1'b1;
          end else begin
            w_beat_nxt = r_beat + BCW'(1);
          end
        end else begin
          w_to_nxt = (r_to == 8'hFF) ? r_to : r_to + 8'h01;
          if (w_to_nxt == 8'(TIMEOUT)) begin
            w_err_nxt = 1'b1;
            w_release = 1'b1;
          end else begin
            w_release = 1'b0;
          end
        end
        // Any release returns to IDLE and demotes the owner to lowest priority.
        if (w_release) begin
          w_state_nxt  = S_IDLE;
          w_grant_nxt  = '0;
          w_beat_nxt   = '0;
          w_to_nxt     = 8'h00;
          w_rr_ptr_nxt = (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + IDW'(1);
        end else begin
          w_state_nxt  = S_GRANT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
      r_to     <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_beat   <= w_beat_nxt;
      r_to     <= w_to_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // RAM and requester outputs; the owner's bus passes straight through during GRANT.
  always_comb begin
    bus.req_wait = '1;
    bus.req_load = 32'h0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0;
    bus.ramstore = 32'h0;
    if (r_state == S_GRANT) begin
      bus.ramaddr  = w_g_addr;
      bus.ramstore = w_g_store;
      bus.ramWEN   = w_g_wen;
      bus.ramREN   = w_g_ren & ~w_g_wen;
      bus.req_load = bus.ramload;
      if (w_done) begin
        bus.req_wait[r_grant] = 1'b0;
      end else begin
        bus.req_wait = '1;
      end
    end else begin
      bus.req_wait = '1;
    end
  end

  assign bus.grant_id = r_grant;
  assign bus.busy     = (r_state == S_GRANT);
  assign bus.err      = r_err;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (NREQ=4, BURST=2, TIMEOUT=8) with immediate assertions.
module tb_ram_port_arbiter;
  logic CLK;
  logic nRST;
  int   n_tests;
  int   n_fail;

  ram_port_arbiter_if #(.NREQ(4)) bus ();

  ram_port_arbiter #(.NREQ(4), .BURST(2), .TIMEOUT(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    #1 nRST = 1'b0;
    #2 nRST = 1'b1;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    n_tests = 0;
    n_fail  = 0;
    bus.req_ren   = 4'b0000;
    bus.req_wen   = 4'b0000;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramload   = 32'h0;
    bus.ramstate  = 2'b00;

    // 1: reset with every requester asserting
    nRST = 1'b0;
    bus.req_ren = 4'b1111;
    #3;
    chk("rst_wait",  32'(bus.req_wait), 32'hF);
    chk("rst_ren",   32'(bus.ramREN),   32'h0);
    chk("rst_wen",   32'(bus.ramWEN),   32'h0);
    chk("rst_err",   32'(bus.err),      32'h0);
    chk("rst_busy",  32'(bus.busy),     32'h0);
    chk("rst_gid",   32'(bus.grant_id), 32'h0);
    chk("rst_addr",  bus.ramaddr,       32'h0);
    bus.req_ren = 4'b0000;
    step();
    nRST = 1'b1;
    step();

    // 2: single read from requester 2, ACCESS arrives on the third grant cycle
    bus.req_ren = 4'b0100;
    bus.req_addr[2*32 +: 32] = 32'h100;
    bus.ramstate = 2'b01;
    bus.ramload  = 32'hCAFE;
    #1;
    chk("idle_noren", 32'(bus.ramREN), 32'h0);
    step();
    chk("rd_gid",   32'(bus.grant_id), 32'h2);
    chk("rd_busy",  32'(bus.busy),     32'h1);
    chk("rd_ren",   32'(bus.ramREN),   32'h1);
    chk("rd_addr",  bus.ramaddr,       32'h100);
    chk("rd_wait0", 32'(bus.req_wait), 32'hF);
    step();
    step();
    bus.ramstate = 2'b10;
    #1;
    chk("rd_beat1_wait", 32'(bus.req_wait), 32'hB);
    chk("rd_beat1_load", bus.req_load,      32'hCAFE);
    step();
    bus.req_addr[2*32 +: 32] = 32'h101;
    #1;
    chk("rd_beat2_wait", 32'(bus.req_wait), 32'hB);
    chk("rd_beat2_addr", bus.ramaddr,       32'h101);
    step();
    chk("rd_rel_busy", 32'(bus.busy),     32'h0);
    chk("rd_rel_wait", 32'(bus.req_wait), 32'hF);
    chk("rd_rel_gid",  32'(bus.grant_id), 32'h0);
    bus.req_ren  = 4'b0000;
    bus.ramstate = 2'b00;

    // 3: all four contend, ACCESS every cycle -> 0,1,2,3,0 with two beats each
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_addr[i*32 +: 32] = 32'h200 + 32'(i);
    bus.req_ren  = 4'b1111;
    bus.ramstate = 2'b10;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_gid_b1",  32'(bus.grant_id), 32'(order[n]));
      chk("rr_wait_b1", 32'(bus.req_wait), 32'(~(4'b0001 << order[n]) & 4'hF));
      chk("rr_addr",    bus.ramaddr,       32'h200 + 32'(order[n]));
      step();
      chk("rr_gid_b2",  32'(bus.grant_id), 32'(order[n]));
      chk("rr_wait_b2", 32'(bus.req_wait), 32'(~(4'b0001 << order[n]) & 4'hF));
      step();
      chk("rr_idle",    32'(bus.busy),     32'h0);
    end
    bus.req_ren  = 4'b0000;
    bus.ramstate = 2'b00;

    // 4: ren and wen together on requester 1 -> write wins
    bus.req_ren = 4'b0010;
    bus.req_wen = 4'b0010;
    bus.req_addr[1*32 +: 32]  = 32'h300;
    bus.req_store[1*32 +: 32] = 32'h1234;
    bus.ramstate = 2'b01;
    step();
    chk("wr_gid",   32'(bus.grant_id), 32'h1);
    chk("wr_wen",   32'(bus.ramWEN),   32'h1);
    chk("wr_ren",   32'(bus.ramREN),   32'h0);
    chk("wr_store", bus.ramstore,      32'h1234);
    chk("wr_addr",  bus.ramaddr,       32'h300);
    bus.req_ren = 4'b0000;
    bus.req_wen = 4'b0000;
    #1;
    chk("wr_drop_wen", 32'(bus.ramWEN), 32'h0);
    step();
    chk("wr_drop_idle", 32'(bus.busy), 32'h0);

    // 5: ramstate stuck BUSY -> timeout after 8 grant cycles, then requester 1 served
    bus.req_ren  = 4'b0011;
    bus.ramstate = 2'b01;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk("to_busy", 32'(bus.busy),     32'h1);
      chk("to_err0", 32'(bus.err),      32'h0);
      chk("to_wait", 32'(bus.req_wait), 32'hF);
      if (k < 8) step();
    end
    step();
    chk("to_err1",   32'(bus.err),  32'h1);
    chk("to_idle",   32'(bus.busy), 32'h0);
    step();
    chk("to_next_gid", 32'(bus.grant_id), 32'h1);
    chk("to_err_sticky", 32'(bus.err),    32'h1);
    bus.ramstate = 2'b11;
    #1;
    chk("er_nopulse", 32'(bus.req_wait), 32'hF);
    bus.req_ren = 4'b0000;
    step();
    chk("er_idle", 32'(bus.busy), 32'h0);
    bus.ramstate = 2'b00;

    // 6: requester drops after beat 1, pointer advances; then async reset mid-burst
    bus.req_ren  = 4'b0100;
    bus.ramstate = 2'b10;
    step();
    chk("drop_gid",  32'(bus.grant_id), 32'h2);
    chk("drop_beat", 32'(bus.req_wait), 32'hB);
    step();
    bus.req_ren = 4'b0000;
    #1;
    chk("drop_wait", 32'(bus.req_wait), 32'hF);
    step();
    chk("drop_idle", 32'(bus.busy), 32'h0);
    bus.req_ren = 4'b0101;
    step();
    chk("drop_rr_gid", 32'(bus.grant_id), 32'h0);
    chk("drop_rr_busy", 32'(bus.busy),    32'h1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy),     32'h0);
    chk("mid_rst_wait", 32'(bus.req_wait), 32'hF);
    chk("mid_rst_ren",  32'(bus.ramREN),   32'h0);
    chk("mid_rst_err",  32'(bus.err),      32'h0);
    chk("mid_rst_load", bus.req_load,      32'h0);
    chk("mid_rst_addr", bus.ramaddr,       32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
